// File: rtl/multiword_serial_adder.sv
// multiword_serial_adder: adds two WIDTH-bit operands SLICE bits per clock
// through a single SLICE-bit ripple-carry slice, holding the carry in a
// flip-flop between slices. Operands arrive and results leave through
// valid/ready handshakes.
// Optional feature macro: RCA_OVF_EN adds the 'ovf' output, which reports
// two's-complement signed overflow of the full-width sum.
module multiword_serial_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
`ifdef RCA_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [SLICE-1:0] a_sl, b_sl, s_sl;
  logic             c_sl;
  logic             last;

  // One ripple-carry slice: pick the current operand slices and add them
  // together with the carry left over from the previous slice.
  always_comb begin
    a_sl = a_q[int'(idx)*SLICE +: SLICE];
    b_sl = b_q[int'(idx)*SLICE +: SLICE];
    {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};
    last = (idx == LAST_IDX);
  end

  // State register; reset drops any operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then write one result slice per
  // ADD cycle; the final slice also produces the carry-out (and overflow).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
`ifdef RCA_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            carry <= Cin;
            idx   <= '0;
            Sum   <= '0;
          end
        end
        ADD: begin
          Sum[int'(idx)*SLICE +: SLICE] <= s_sl;
          carry <= c_sl;
          idx   <= idx + 1'b1;
          if (last) begin
            Cout <= c_sl;
`ifdef RCA_OVF_EN
            ovf  <= c_sl ^ (a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ s_sl[SLICE-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_serial_adder.sv
// Self-checking bench for multiword_serial_adder. Expected results are
// computed by a full-width reference model when operands are accepted,
// queued in a scoreboard and compared when the DUT presents its result.
module tb_multiword_serial_adder;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             busy;
`ifdef RCA_OVF_EN
  logic             ovf;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  exp_t ex;

  int tests_run;
  int tests_failed;

  multiword_serial_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
`ifdef RCA_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: full-width add plus sign-rule signed overflow.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin);
    exp_t e;
    logic [WIDTH:0] full;
    full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // Present operands for one edge (starting at a negedge) and queue the
  // expected result; returns at the negedge after the accept edge.
  task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin);
    A        = a;
    B        = b;
    Cin      = cin;
    in_valid = 1'b1;
    sb.push_back(model(a, b, cin));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; edges counts clock edges since accept.
  task automatic wait_result(output int edges);
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(negedge clk);
      edges++;
    end
  endtask

  // Complete the output handshake with a single out_ready edge.
  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pop_expected(output exp_t e, input string name);
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL %s: scoreboard empty when result expected", name);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               in_ready, out_valid, busy);
    end
    tests_run++;
    if (Sum !== '0 || Cout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: Sum=%h Cout=%b, required 0000 0", Sum, Cout);
    end
`ifdef RCA_OVF_EN
    tests_run++;
    if (ovf !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ovf: ovf=%b, required 0", ovf);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Directed operand table covering ones, mid-word carries and full ripple.
  task automatic test_basic();
    logic [WIDTH-1:0] ta [4];
    logic [WIDTH-1:0] tb [4];
    logic             tc [4];
    int edges;
    ta = '{16'h0001, 16'h0BB0, 16'hFFFF, 16'hFFFF};
    tb = '{16'h0000, 16'h0660, 16'h0001, 16'hFFFF};
    tc = '{1'b0,     1'b1,     1'b0,     1'b1};
    for (int i = 0; i < 4; i++) begin
      drive_op(ta[i], tb[i], tc[i]);
      tests_run++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL basic_accept[%0d]: in_ready=%b busy=%b, required 0 1",
                 i, in_ready, busy);
      end
      wait_result(edges);
      tests_run++;
      if (edges != NSLICE) begin
        tests_failed++;
        $display("[TB] FAIL basic_latency[%0d]: %0d edges, required %0d", i, edges, NSLICE);
      end
      pop_expected(ex, "basic_sb");
      tests_run++;
      if (Sum !== ex.sum || Cout !== ex.cout) begin
        tests_failed++;
        $display("[TB] FAIL basic_result[%0d]: Sum=%h Cout=%b, required %h %b",
                 i, Sum, Cout, ex.sum, ex.cout);
      end
      release_result();
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL basic_release[%0d]: in_ready=%b out_valid=%b, required 1 0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  // Hold the result under backpressure while new operands are offered.
  task automatic test_backpressure();
    int edges;
    int bad;
    drive_op(16'h1234, 16'h1111, 1'b0);
    wait_result(edges);
    pop_expected(ex, "bp_sb");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      A        = 16'(i * 16'h0101);
      B        = 16'hA5A5;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Sum !== ex.sum || Cout !== ex.cout) begin
        tests_failed++;
        bad++;
        $display("[TB] FAIL bp_hold[%0d]: out_valid=%b in_ready=%b Sum=%h, required 1 0 %h",
                 i, out_valid, in_ready, Sum, ex.sum);
      end
    end
    in_valid = 1'b0;
    release_result();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_release: in_ready=%b out_valid=%b, required 1 0",
               in_ready, out_valid);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_no_new_op: busy=%b in_ready=%b, required 0 1", busy, in_ready);
    end
  endtask

  // Operand changes and in_valid pulses while busy must not disturb anything.
  task automatic test_no_overlap();
    int edges;
    drive_op(16'h4321, 16'h1C3D, 1'b0);
    edges = 0;
    while (!out_valid && edges < 50) begin
      A        = 16'($urandom);
      B        = 16'($urandom);
      Cin      = 1'($urandom);
      in_valid = ~in_valid;
      @(negedge clk);
      edges++;
    end
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    pop_expected(ex, "ovl_sb");
    tests_run++;
    if (out_valid !== 1'b1 || Sum !== ex.sum || Cout !== ex.cout) begin
      tests_failed++;
      $display("[TB] FAIL ovl_result: out_valid=%b Sum=%h Cout=%b, required 1 %h %b",
               out_valid, Sum, Cout, ex.sum, ex.cout);
    end
    release_result();
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ovl_idle: busy=%b out_valid=%b in_ready=%b, required 0 0 1",
               busy, out_valid, in_ready);
    end
  endtask

  // Asynchronous reset in the middle of ADD discards the partial result.
  task automatic test_reset_mid();
    int edges;
    int seen;
    drive_op(16'h00FF, 16'h0F0F, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    void'(sb.pop_back());
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        Sum !== '0 || Cout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_async: in_ready=%b out_valid=%b busy=%b Sum=%h Cout=%b, required 1 0 0 0000 0",
               in_ready, out_valid, busy, Sum, Cout);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_no_output: out_valid seen %0d times, required 0", seen);
    end
    drive_op(16'h0005, 16'h0003, 1'b1);
    wait_result(edges);
    pop_expected(ex, "rstmid_sb");
    tests_run++;
    if (edges != NSLICE || Sum !== ex.sum || Cout !== ex.cout) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_newop: edges=%0d Sum=%h Cout=%b, required %0d %h %b",
               edges, Sum, Cout, NSLICE, ex.sum, ex.cout);
    end
    release_result();
  endtask

  // Signed overflow boundaries (Sum/Cout always, ovf when the port exists).
  task automatic test_ovf();
    logic [WIDTH-1:0] ta [2];
    logic [WIDTH-1:0] tb [2];
    int edges;
    ta = '{16'h7FFF, 16'hFFFF};
    tb = '{16'h0001, 16'h0001};
    for (int i = 0; i < 2; i++) begin
      drive_op(ta[i], tb[i], 1'b0);
      wait_result(edges);
      pop_expected(ex, "ovf_sb");
      tests_run++;
      if (Sum !== ex.sum || Cout !== ex.cout) begin
        tests_failed++;
        $display("[TB] FAIL ovf_result[%0d]: Sum=%h Cout=%b, required %h %b",
                 i, Sum, Cout, ex.sum, ex.cout);
      end
`ifdef RCA_OVF_EN
      tests_run++;
      if (ovf !== ex.ovf) begin
        tests_failed++;
        $display("[TB] FAIL ovf_flag[%0d]: ovf=%b, required %b", i, ovf, ex.ovf);
      end
`endif
      release_result();
    end
  endtask

  // Random operands with random consumer delay, checked against the model.
  task automatic test_random();
    int edges;
    int delay;
    for (int i = 0; i < 1000; i++) begin
      drive_op(16'($urandom), 16'($urandom), 1'($urandom));
      wait_result(edges);
      delay = $urandom_range(0, 2);
      repeat (delay) @(negedge clk);
      pop_expected(ex, "rand_sb");
      tests_run++;
      if (edges != NSLICE || out_valid !== 1'b1 || Sum !== ex.sum || Cout !== ex.cout) begin
        tests_failed++;
        $display("[TB] FAIL rand[%0d]: edges=%0d out_valid=%b Sum=%h Cout=%b, required %0d 1 %h %b",
                 i, edges, out_valid, Sum, Cout, NSLICE, ex.sum, ex.cout);
      end
`ifdef RCA_OVF_EN
      tests_run++;
      if (ovf !== ex.ovf) begin
        tests_failed++;
        $display("[TB] FAIL rand_ovf[%0d]: ovf=%b, required %b", i, ovf, ex.ovf);
      end
`endif
      release_result();
    end
  endtask

  // Run every scenario in sequence, then report.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    A            = '0;
    B            = '0;
    Cin          = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_no_overlap();
    test_reset_mid();
    test_ovf();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
